// File: rtl/mc_controller_v2.sv
// mc_controller_v2: multi-cycle MIPS control unit (Moore FSM + ALU-control decode)
// with mem_ready wait states, memory-access timeout, sticky fault cause and a
// retired-instruction counter. Control outputs decode combinationally from the
// current state; opcode, funct and mem_ready qualify them where needed.
module mc_controller_v2 #(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               pc_write,
  output logic               branch,
  output logic               branch_ne,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               imm_zext,
  output logic [1:0]         pc_src,
  output logic [2:0]         alu_ctl,
  output logic [3:0]         state,
  output logic [1:0]         fault,
  output logic               instr_done,
  output logic [CNT_W-1:0]   instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11,
    S_FAULT  = 4'd15
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  localparam logic [FUNCT_W-1:0] F_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] F_SUB = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] F_AND = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] F_OR  = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] F_SLT = FUNCT_W'(6'b101010);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;

  // The wait counter only has to reach TIMEOUT-1: at that value the access
  // either completes or faults, so it never needs to hold TIMEOUT itself.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t             state_q, state_d;
  logic [1:0]         fault_q, fault_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_wait;

  // Output decode, next-state selection, wait-counter and fault/count updates.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    fault_d    = fault_q;
    wait_d     = '0;
    cnt_d      = cnt_q;
    mem_wait   = 1'b0;
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    imm_zext   = 1'b0;
    pc_src     = 2'b00;
    alu_ctl    = ALU_ADD;
    instr_done = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_wait  = 1'b1;
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:                  state_d = S_EXEC;
          OP_LW, OP_SW:              state_d = S_MEMADR;
          OP_BEQ, OP_BNE:            state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IMMEX;
          OP_J:                      state_d = S_JUMP;
          default: begin
            state_d = S_FAULT;
            fault_d = FLT_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_wait = 1'b1;
        mem_req  = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_wait  = 1'b1;
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        state_d   = S_ALUWB;
        case (funct)
          F_ADD: alu_ctl = ALU_ADD;
          F_SUB: alu_ctl = ALU_SUB;
          F_AND: alu_ctl = ALU_AND;
          F_OR:  alu_ctl = ALU_OR;
          F_SLT: alu_ctl = ALU_SLT;
          default: begin
            state_d = S_FAULT;
            fault_d = FLT_ILLEGAL;
          end
        endcase
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b00;
        alu_ctl    = ALU_SUB;
        pc_src     = 2'b01;
        branch     = (opcode == OP_BEQ);
        branch_ne  = (opcode == OP_BNE);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_IMMWB;
        if (opcode == OP_ANDI) begin
          alu_ctl  = ALU_AND;
          imm_zext = 1'b1;
        end else if (opcode == OP_ORI) begin
          alu_ctl  = ALU_OR;
          imm_zext = 1'b1;
        end
      end
      S_IMMWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
        fault_d = FLT_ILLEGAL;
      end
    endcase

    // A stalled memory access counts its wait cycles; reaching the limit
    // with mem_ready still low aborts into FAULT. mem_ready on the limit
    // cycle completes normally because the branch below is not taken.
    if (mem_wait && !mem_ready) begin
      if ((TIMEOUT > 0) && (wait_q == WAIT_LAST)) begin
        state_d = S_FAULT;
        fault_d = FLT_TIMEOUT;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end

    if (instr_done) cnt_d = cnt_q + 1'b1;
  end

  // State, sticky fault cause, wait counter and retired count; synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_FETCH;
      fault_q <= FLT_NONE;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state       = state_q;
  assign fault       = fault_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_controller_v2.sv
// Bench for mc_controller_v2. The driver walks instruction-level sequences
// (which states an instruction visits, how long memory stalls) and pushes the
// expected per-cycle response; a separate monitor pops and compares.
module tb_mc_controller_v2;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 8;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             mem_ready;
  logic             mem_req, iord, mem_write, ir_write, pc_write, branch, branch_ne;
  logic             reg_write, reg_dst, mem_to_reg, alu_src_a, imm_zext, instr_done;
  logic [1:0]       alu_src_b, pc_src, fault;
  logic [2:0]       alu_ctl;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  mc_controller_v2 #(.OP_W(6), .FUNCT_W(6), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .branch_ne(branch_ne), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_zext(imm_zext), .pc_src(pc_src), .alu_ctl(alu_ctl),
    .state(state), .fault(fault), .instr_done(instr_done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       st;
    logic [15:0]      ctrl;
    logic [2:0]       alu;
    logic [1:0]       flt;
    logic             done;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             exp_q[$];
  int               n_checks = 0;
  int               n_pass   = 0;
  logic [CNT_W-1:0] m_cnt    = '0;
  logic [1:0]       m_fault  = 2'b00;
  bit               m_dead   = 1'b0;

  logic [15:0] dut_ctrl;
  assign dut_ctrl = {mem_req, iord, mem_write, ir_write, pc_write, branch, branch_ne,
                     reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, imm_zext, pc_src};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
  endtask

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      FN_ADD:  return 3'b010;
      FN_SUB:  return 3'b110;
      FN_AND:  return 3'b000;
      FN_OR:   return 3'b001;
      FN_SLT:  return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic bit funct_ok(input logic [5:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

  // Expected control outputs for one cycle, straight from the state table.
  function automatic exp_t make_exp(input int st, input logic [5:0] op, input logic [5:0] fn,
                                    input logic mr, input logic retire);
    logic mreq, io, mw, irw, pcw, br, bn, rw, rd, m2r, asa, zx;
    logic [1:0] asb, pcs;
    logic [2:0] alu;
    exp_t e;
    {mreq, io, mw, irw, pcw, br, bn, rw, rd, m2r, asa, zx} = '0;
    asb = 2'b00; pcs = 2'b00; alu = 3'b010;
    case (st)
      0:  begin mreq = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mreq = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mreq = 1; io = 1; mw = 1; end
      6:  begin asa = 1; alu = funct_alu(fn); end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; alu = 3'b110; pcs = 2'b01; br = (op == OP_BEQ); bn = (op == OP_BNE); end
      9:  begin
            asa = 1; asb = 2'b10;
            if (op == OP_ANDI) begin alu = 3'b000; zx = 1; end
            else if (op == OP_ORI) begin alu = 3'b001; zx = 1; end
          end
      10: rw = 1;
      11: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    e.st   = 4'(st);
    e.ctrl = {mreq, io, mw, irw, pcw, br, bn, rw, rd, m2r, asa, asb, zx, pcs};
    e.alu  = alu;
    e.flt  = m_fault;
    e.done = retire;
    e.cnt  = m_cnt;
    return e;
  endfunction

  // One clock of stimulus: drive mem_ready, queue the expected response, advance.
  task automatic cyc(input int st, input logic mr, input logic retire);
    mem_ready = mr;
    exp_q.push_back(make_exp(st, opcode, funct, mr, retire));
    if (retire) m_cnt = m_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic enter_fault(input logic [1:0] code, input int hold);
    m_fault = code;
    m_dead  = 1'b1;
    repeat (hold) cyc(15, rnd_bit(), 1'b0);
  endtask

  // A memory access stalled for 'waits' cycles; past the limit it faults.
  task automatic mem_phase(input int st, input int waits, output bit timed_out);
    int n;
    timed_out = (TIMEOUT > 0) && (waits >= TIMEOUT);
    n = timed_out ? TIMEOUT : waits;
    for (int i = 0; i < n; i++) cyc(st, 1'b0, 1'b0);
    if (timed_out) enter_fault(2'b10, 3);
    else cyc(st, 1'b1, st == 5);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fetch_waits, input int mem_waits);
    bit to;
    opcode = op;
    funct  = fn;
    mem_phase(0, fetch_waits, to);
    if (to) return;
    cyc(1, rnd_bit(), 1'b0);
    case (op)
      OP_R: begin
        cyc(6, rnd_bit(), 1'b0);
        if (funct_ok(fn)) cyc(7, rnd_bit(), 1'b1);
        else enter_fault(2'b01, 3);
      end
      OP_LW: begin
        cyc(2, rnd_bit(), 1'b0);
        mem_phase(3, mem_waits, to);
        if (!to) cyc(4, rnd_bit(), 1'b1);
      end
      OP_SW: begin
        cyc(2, rnd_bit(), 1'b0);
        mem_phase(5, mem_waits, to);
      end
      OP_BEQ, OP_BNE: cyc(8, rnd_bit(), 1'b1);
      OP_ADDI, OP_ANDI, OP_ORI: begin
        cyc(9, rnd_bit(), 1'b0);
        cyc(10, rnd_bit(), 1'b1);
      end
      OP_J: cyc(11, rnd_bit(), 1'b1);
      default: enter_fault(2'b01, 3);
    endcase
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    mem_ready = rnd_bit();
    repeat (cycles) @(posedge clk);
    #1;
    rst     = 1'b0;
    m_cnt   = '0;
    m_fault = 2'b00;
    m_dead  = 1'b0;
  endtask

  // Monitor: compare whatever the driver queued for this cycle, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state",       64'(state),       64'(e.st));
        check("ctrl",        64'(dut_ctrl),    64'(e.ctrl));
        check("alu_ctl",     64'(alu_ctl),     64'(e.alu));
        check("fault",       64'(fault),       64'(e.flt));
        check("instr_done",  64'(instr_done),  64'(e.done));
        check("instr_count", 64'(instr_count), 64'(e.cnt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Driver: directed scenarios, then random legal traffic, then random with faults.
  initial begin
    logic [5:0] legal_ops [9];
    logic [5:0] legal_fns [5];
    bit to;
    legal_ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J};
    legal_fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    opcode = OP_ADDI;
    funct  = FN_ADD;
    mem_ready = 1'b1;
    do_reset(2);

    run_instr(OP_ADDI, FN_ADD, 0, 0);
    run_instr(OP_ORI,  FN_ADD, 0, 0);
    run_instr(OP_R,    FN_SLT, 0, 0);
    run_instr(OP_LW,   FN_ADD, 0, 3);
    run_instr(OP_SW,   FN_ADD, 1, 2);
    run_instr(OP_BNE,  FN_ADD, 0, 0);
    run_instr(OP_BEQ,  FN_ADD, 0, 0);
    run_instr(OP_J,    FN_ADD, 2, 0);
    run_instr(OP_ANDI, FN_OR,  0, 0);
    foreach (legal_fns[i]) run_instr(OP_R, legal_fns[i], 0, 0);

    // Ready on the last allowed wait cycle completes; one more wait faults.
    run_instr(OP_ADDI, FN_ADD, TIMEOUT - 1, 0);
    run_instr(OP_LW,   FN_ADD, 0, TIMEOUT - 1);
    run_instr(OP_ADDI, FN_ADD, TIMEOUT, 0);
    do_reset(1);
    run_instr(OP_LW, FN_ADD, 0, TIMEOUT);
    do_reset(1);
    run_instr(OP_SW, FN_ADD, 0, TIMEOUT + 1);
    do_reset(1);

    // Illegal opcode, held in FAULT, then reset from FAULT.
    run_instr(OP_ADDI, FN_ADD, 0, 0);
    opcode = 6'b111111;
    cyc(0, 1'b1, 1'b0);
    cyc(1, 1'b0, 1'b0);
    enter_fault(2'b01, 10);
    do_reset(1);
    run_instr(OP_R, 6'b000000, 0, 0);
    do_reset(1);

    // Reset in the middle of a stalled load.
    run_instr(OP_J, FN_ADD, 0, 0);
    opcode = OP_LW;
    cyc(0, 1'b1, 1'b0);
    cyc(1, 1'b1, 1'b0);
    cyc(2, 1'b1, 1'b0);
    cyc(3, 1'b0, 1'b0);
    cyc(3, 1'b0, 1'b0);
    do_reset(1);
    run_instr(OP_BEQ, FN_ADD, 0, 0);

    // Random legal traffic, long enough to wrap the counter.
    for (int k = 0; k < 300; k++)
      run_instr(legal_ops[$urandom_range(0, 8)], legal_fns[$urandom_range(0, 4)],
                $urandom_range(0, TIMEOUT - 1), $urandom_range(0, TIMEOUT - 1));

    // Random traffic including illegal codes and timeouts.
    for (int k = 0; k < 150; k++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 8)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 4)];
      run_instr(op, fn, $urandom_range(0, TIMEOUT + 1), $urandom_range(0, TIMEOUT + 1));
      if (m_dead) do_reset(1);
    end

    to = 1'b0;
    repeat (2) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_controller_v2.md
Name: mc_controller_v2

Overview:
- Next-generation multi-cycle MIPS control unit: Moore FSM plus integrated ALU-control decode, driving the existing multi-cycle datapath (PC, IR, register file, ALUOut, unified memory).
- Extends the prior controller in four ways:
  - adds andi/ori (zero-extended immediates) and bne;
  - inserts memory wait states on a mem_ready handshake, with a parametrised timeout;
  - adds a sticky fault state with a cause code;
  - adds a retired-instruction counter.

Parameters:
OP_W, 6, opcode field width
FUNCT_W, 6, funct field width
TIMEOUT, 16, max wait cycles per memory access before fault; 0 disables timeout
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
opcode  in  OP_W  IR[31:26], stable from DECODE until instruction end
funct  in  FUNCT_W  IR[5:0]
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory access requested
iord  out  1  0 = PC address, 1 = ALUOut address
mem_write  out  1  write strobe
ir_write  out  1  IR load
pc_write  out  1  unconditional PC load
branch  out  1  PC load if ALU zero (beq)
branch_ne  out  1  PC load if ALU not zero (bne)
reg_write  out  1  register file write
reg_dst  out  1  1 = rd, 0 = rt
mem_to_reg  out  1  1 = data register, 0 = ALUOut
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = 4, 10 = immediate, 11 = immediate<<2
imm_zext  out  1  1 = zero-extend immediate, 0 = sign-extend
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
alu_ctl  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
state  out  4  current state encoding
fault  out  2  00 none, 01 illegal opcode/funct, 10 memory timeout; sticky
instr_done  out  1  one-cycle pulse when an instruction retires
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=1 at posedge): state=FETCH(0), fault=00, wait counter=0, instr_count=0. Outputs are Moore-combinational from state, so post-reset outputs are FETCH values. rst mid-instruction or mid-wait aborts with no further writes.
- Defaults for any output not listed in a state: 0; alu_ctl=010.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, j 000010.
- Funct codes: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- States (encoding: name: outputs -> transition):
  - 0 FETCH: mem_req=1, alu_src_b=01, alu_ctl=add; ir_write=pc_write=mem_ready -> DECODE when mem_ready, else stay.
  - 1 DECODE: alu_src_b=11, add -> R:EXEC, lw/sw:MEMADR, beq/bne:BRANCH, addi/andi/ori:IMMEX, j:JUMP, other: FAULT with fault=01.
  - 2 MEMADR: alu_src_a=1, alu_src_b=10, add -> lw:MEMRD, sw:MEMWR.
  - 3 MEMRD: mem_req=1, iord=1 -> MEMWB when mem_ready.
  - 4 MEMWB: reg_write=1, mem_to_reg=1 -> FETCH, retire.
  - 5 MEMWR: mem_req=1, iord=1, mem_write=1 -> FETCH, retire when mem_ready.
  - 6 EXEC: alu_src_a=1, alu_src_b=00, alu_ctl from funct -> ALUWB; unsupported funct -> FAULT with fault=01.
  - 7 ALUWB: reg_write=1, reg_dst=1 -> FETCH, retire.
  - 8 BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01; branch=1 (beq) or branch_ne=1 (bne) -> FETCH, retire.
  - 9 IMMEX: alu_src_a=1, alu_src_b=10; addi: add, imm_zext=0; andi: and, imm_zext=1; ori: or, imm_zext=1 -> IMMWB.
  - 10 IMMWB: reg_write=1 -> FETCH, retire.
  - 11 JUMP: pc_write=1, pc_src=10 -> FETCH, retire.
  - 15 FAULT: all control strobes 0, instr_done=0 -> stays until rst.
  - Encodings 12-14: next state FAULT with fault=01.
- Retire: instr_done=1 combinationally in the retiring cycle; instr_count increments at that clock edge.
- Wait counter:
  - Counts consecutive cycles in FETCH/MEMRD/MEMWR with mem_ready=0; clears on any state change.
  - If TIMEOUT>0 and the counter equals TIMEOUT-1 with mem_ready=0, next state is FAULT with fault=10.
  - mem_ready=1 on that same cycle wins: normal completion, no fault.
- fault is written only on entry to FAULT and never cleared except by rst.

Test Plan:
- rst=1 two cycles, mem_ready=1, opcode=addi -> states 0,1,9,10,0; alu_src_b=10, imm_zext=0 in IMMEX; reg_write=1 in IMMWB; instr_count=1 after 4 cycles.
- opcode=ori, then R-type with funct=101010 -> IMMEX shows alu_ctl=001, imm_zext=1; EXEC shows alu_ctl=111; ALUWB shows reg_dst=1; instr_count=2.
- lw, mem_ready low for 3 cycles in MEMRD -> stays in state 3 for 3 extra cycles with mem_req=1, iord=1; MEMWB shows mem_to_reg=1; total 8 cycles including FETCH.
- TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT after 4 cycles, fault=10, all strobes 0; mem_ready=1 exactly on cycle 4 -> DECODE, no fault.
- opcode=bne, then beq -> BRANCH shows branch_ne=1, branch=0, alu_ctl=110, pc_src=01; the beq BRANCH shows branch=1, branch_ne=0.
- opcode=111111 -> FAULT with fault=01, held 10 cycles; rst mid-FAULT -> FETCH, fault=00, instr_count=0.
